// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one single-port memory among NUM_REQ requesters, round-robin with optional grant locking.
// Latency: accepted command appears on mem_* next cycle; read data returns on rsp_* RD_LAT+1 cycles after mem_rd_en.
// Backpressure: req_ready is a combinational one-hot accept; losers hold their request, responses cannot be stalled.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   req_valid/req_we/req_lock  per-requester command valid, write(1)/read(0), keep-grant request
//   req_addr/req_wdata         flattened per-requester address and write data (requester i at [i*W +: W])
//   req_ready                  one-hot accept to the winning requester
//   rsp_valid/rsp_rdata        one-hot read-response strobe and its data
//   mem_addr/mem_wr_en/mem_rd_en/mem_wdata/mem_rdata   registered memory command port, read data in
//
// Build option: define MEM_ARB_PRIO_EN to give requester 0 fixed priority over round-robin while unlocked.

module mem_rr_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int                ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                CNT_W      = 4;
    localparam logic [CNT_W-1:0]  MAX_LOCK_C = CNT_W'(MAX_LOCK);
    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    // Successor of a requester id, wrapping at NUM_REQ (not at a power of two).
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic                mem_rd_en_q, mem_rd_en_d;

    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    // Read-tracking pipeline: stage 0 lines up with mem_rd_en, stage RD_LAT with mem_rdata.
    logic [RD_LAT:0]     pipe_vld_q, pipe_vld_d;
    logic [ID_W-1:0]     pipe_id_q [0:RD_LAT];
    logic [ID_W-1:0]     pipe_id_d [0:RD_LAT];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                rr_vld;
    logic [ID_W-1:0]     rr_idx;
    logic                prio0;
    logic                win_vld;
    logic [ID_W-1:0]     win_idx;
    logic [CNT_W-1:0]    lock_cnt_inc;

    logic                xfer_vld;
    logic [ID_W-1:0]     xfer_idx;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand   = '0;
        rr_vld = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!rr_vld && req_valid[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
    end

`ifdef MEM_ARB_PRIO_EN
    // Requester 0 jumps the round-robin queue whenever the grant is unlocked.
    assign prio0 = req_valid[0];
`else
    assign prio0 = 1'b0;
`endif

    assign win_vld      = prio0 | rr_vld;
    assign win_idx      = prio0 ? '0 : rr_idx;
    assign lock_cnt_inc = lock_cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        xfer_vld   = 1'b0;
        xfer_idx   = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    xfer_vld = 1'b1;
                    xfer_idx = win_idx;
                    // A priority grant to requester 0 leaves the rotation untouched.
                    if (!prio0) begin
                        rr_ptr_d = next_id(win_idx);
                    end
                    // With MAX_LOCK == 1 the first grant already uses up the budget.
                    if (req_lock[win_idx] && (MAX_LOCK > 1)) begin
                        state_d    = ST_LOCKED;
                        owner_d    = win_idx;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
            end

            ST_LOCKED: begin
                if (req_valid[owner_q]) begin
                    xfer_vld   = 1'b1;
                    xfer_idx   = owner_q;
                    lock_cnt_d = lock_cnt_inc;
                    if (!req_lock[owner_q] || (lock_cnt_inc >= MAX_LOCK_C)) begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                        rr_ptr_d   = next_id(owner_q);
                    end
                end else begin
                    // Owner let go for a cycle: the lock is released, nobody is granted.
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    rr_ptr_d   = next_id(owner_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (xfer_vld) begin
            req_ready[xfer_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command mux and memory command register
    // ------------------------------------------------------------------
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer_idx == ID_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_we    = req_we[i];
            end
        end
    end

    always_comb begin
        mem_addr_d  = xfer_vld ? sel_addr  : mem_addr_q;
        mem_wdata_d = xfer_vld ? sel_wdata : mem_wdata_q;
        mem_wr_en_d = xfer_vld &  sel_we;
        mem_rd_en_d = xfer_vld & ~sel_we;
    end

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    always_comb begin
        pipe_vld_d[0] = xfer_vld & ~sel_we;
        pipe_id_d[0]  = xfer_idx;
        for (int s = 1; s <= RD_LAT; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_id_d[s]  = pipe_id_q[s-1];
        end

        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (pipe_vld_q[RD_LAT]) begin
            rsp_valid_d[pipe_id_q[RD_LAT]] = 1'b1;
            rsp_rdata_d                    = mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            pipe_vld_q  <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                pipe_id_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int s = 0; s <= RD_LAT; s++) begin
                pipe_id_q[s] <= pipe_id_d[s];
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_rd_en = mem_rd_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares the single-port 8x8 memory (addr/wr_en/rd_en/wdata/rdata) between NUM_REQ requesters using round-robin arbitration, with optional grant locking for back-to-back bursts.
- Sits between requester agents/masters and the memory port.
- Issues at most one memory command per cycle and routes read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 3, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, memory read latency in cycles (1..4)
- MAX_LOCK, 4, maximum consecutive grants one requester may hold via req_lock (1..15)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester command valid
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_lock  input  NUM_REQ  request to keep the grant for the next command
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  flattened write data
- req_ready  output  NUM_REQ  one-hot accept, combinational
- rsp_valid  output  NUM_REQ  one-hot read-response strobe
- rsp_rdata  output  DATA_W  read data, qualified by rsp_valid
- mem_addr  output  ADDR_W  memory address
- mem_wr_en  output  1  memory write enable
- mem_rd_en  output  1  memory read enable
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data

Behaviour:
- Clock port is clk; reset port is reset. Reset is asynchronous, active-high.
- Reset values:
  - mem_addr, mem_wr_en, mem_rd_en, mem_wdata, rsp_valid, rsp_rdata all 0.
  - Round-robin pointer rr_ptr = 0; lock counter = 0; FSM = IDLE.
  - Read-tracking pipeline cleared.
- Arbitration:
  - Search order starts at rr_ptr and wraps modulo NUM_REQ.
  - The first requester with req_valid high wins; req_ready is high for the winner only.
  - A transfer occurs when req_valid[i] && req_ready[i].
- On a transfer in cycle T (registered outputs):
  - Cycle T+1: mem_addr/mem_wdata take requester i's values; mem_wr_en = req_we[i]; mem_rd_en = !req_we[i].
  - mem_wr_en and mem_rd_en are never both high.
  - With no transfer, both enables are 0 the next cycle; addr/wdata hold their last values.
- rr_ptr update on a transfer in IDLE, or on leaving LOCKED: rr_ptr <= (i+1) mod NUM_REQ.
- FSM:
  - IDLE: on a transfer with req_lock[i]=1, go to LOCKED, record owner = i, set lock_cnt = 1.
  - LOCKED:
    - Only the owner can receive req_ready; other requesters are blocked.
    - Each owner transfer increments lock_cnt.
    - Exit to IDLE when any of these holds: the owner transfers with req_lock=0; lock_cnt reaches MAX_LOCK at a transfer; or the owner drops req_valid for one cycle.
    - On exit, rr_ptr = owner+1.
- Read return:
  - A read issued with mem_rd_en high in cycle T+1 has mem_rdata valid in cycle T+1+RD_LAT.
  - In that cycle the arbiter registers the data, so rsp_valid[i]=1 and rsp_rdata = data in cycle T+2+RD_LAT, for exactly one cycle.
  - Requester ids travel through a valid+id shift pipeline of depth RD_LAT+1.
  - Back-to-back reads from different requesters are fully pipelined, one per cycle.
- Writes produce no response.
- Asserting reset mid-operation drops in-flight reads (no rsp_valid) and returns the FSM to IDLE immediately.

Optional Feature:
- MEM_ARB_PRIO_EN defined: requester 0 has fixed highest priority in IDLE, ahead of round-robin. It cannot preempt LOCKED. The rr_ptr rule is unchanged for requesters 1..NUM_REQ-1.
- Not defined: pure round-robin as described above.

Test Plan:
- Reset, all req_valid=0 -> all outputs 0, no mem_*_en ever asserted.
- Req0 writes addr 3 / 0xA5, then reads addr 3 -> mem_wr_en=1 with addr 3 / 0xA5 at T+1; read gives rsp_valid=2'b01 with rsp_rdata=0xA5 at T+3 (RD_LAT=1).
- Both requesters hold valid reads for 4 cycles -> grants alternate 0,1,0,1; rsp_valid alternates, one per cycle, ids correct.
- Req1 sets req_lock=1 for 6 commands while req0 is valid -> req1 gets 4 consecutive grants (MAX_LOCK), then req0 is granted.
- Reset asserted the cycle after a read issues -> no rsp_valid; FSM in IDLE; rr_ptr=0 after release.
- With MEM_ARB_PRIO_EN, both requesters continuously valid -> req0 wins every IDLE cycle; without the macro -> alternation.
